// File: rtl/vga_pkg.sv
// Shared VGA constants and enumerations used by the output-stage blocks.
package vga_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        BLANKING
    } mux_state_t;

    // Screen states double as draw-layer select indices for the frame mux.
    typedef enum logic [1:0] {
        SCREEN_START = 2'd0,
        SCREEN_GAME  = 2'd1,
        SCREEN_OVER  = 2'd2
    } screen_t;

endpackage

// File: rtl/vga_src_sel.sv
// Combinational N-way picker over the packed per-source VGA buses.
module vga_src_sel #(
    parameter int N_SRC = 4,
    parameter int SEL_W = $clog2(N_SRC),
    parameter int RGB_W = vga_pkg::RGB_W,
    parameter int CNT_W = vga_pkg::CNT_W
) (
    input  logic [SEL_W-1:0]       idx_i,
    input  logic [N_SRC*CNT_W-1:0] hcount_i,
    input  logic [N_SRC*CNT_W-1:0] vcount_i,
    input  logic [N_SRC-1:0]       hsync_i,
    input  logic [N_SRC-1:0]       vsync_i,
    input  logic [N_SRC-1:0]       hblnk_i,
    input  logic [N_SRC-1:0]       vblnk_i,
    input  logic [N_SRC*RGB_W-1:0] rgb_i,
    output logic [CNT_W-1:0]       hcount_o,
    output logic [CNT_W-1:0]       vcount_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   hblnk_o,
    output logic                   vblnk_o,
    output logic [RGB_W-1:0]       rgb_o
);

    // Out-of-range indices fall through to all-zero rather than reading past the bus.
    always_comb begin
        hcount_o = '0;
        vcount_o = '0;
        hsync_o  = 1'b0;
        vsync_o  = 1'b0;
        hblnk_o  = 1'b0;
        vblnk_o  = 1'b0;
        rgb_o    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (idx_i == SEL_W'(i)) begin
                hcount_o = hcount_i[i*CNT_W +: CNT_W];
                vcount_o = vcount_i[i*CNT_W +: CNT_W];
                hsync_o  = hsync_i[i];
                vsync_o  = vsync_i[i];
                hblnk_o  = hblnk_i[i];
                vblnk_o  = vblnk_i[i];
                rgb_o    = rgb_i[i*RGB_W +: RGB_W];
            end
        end
    end

endmodule

// File: rtl/vga_frame_mux.sv
// Frame-synchronous N-source VGA selector with optional black transition frames.
module vga_frame_mux #(
    parameter int N_SRC        = 4,
    parameter int SEL_W        = $clog2(N_SRC),
    parameter int RGB_W        = vga_pkg::RGB_W,
    parameter int CNT_W        = vga_pkg::CNT_W,
    parameter int BLANK_FRAMES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*CNT_W-1:0] src_hcount,
    input  logic [N_SRC*CNT_W-1:0] src_vcount,
    input  logic [N_SRC-1:0]       src_hsync,
    input  logic [N_SRC-1:0]       src_vsync,
    input  logic [N_SRC-1:0]       src_hblnk,
    input  logic [N_SRC-1:0]       src_vblnk,
    input  logic [N_SRC*RGB_W-1:0] src_rgb,
    output logic [CNT_W-1:0]       out_hcount,
    output logic [CNT_W-1:0]       out_vcount,
    output logic                   out_hsync,
    output logic                   out_vsync,
    output logic                   out_hblnk,
    output logic                   out_vblnk,
    output logic [RGB_W-1:0]       out_rgb,
    output logic [SEL_W-1:0]       active_sel,
    output logic                   switching
);

    import vga_pkg::*;

    localparam int unsigned N_SRC_U = N_SRC;
    localparam int          BLANK_W = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);

    mux_state_t         state_q, state_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [SEL_W-1:0]   activeSel_q, activeSel_d;
    logic [BLANK_W-1:0] blankCnt_q, blankCnt_d;

    logic               selValid;
    logic               sof;

    logic [CNT_W-1:0]   pickHcount, pickVcount;
    logic               pickHsync, pickVsync, pickHblnk, pickVblnk;
    logic [RGB_W-1:0]   pickRgb;

    logic [CNT_W-1:0]   outHcount_q, outVcount_q;
    logic               outHsync_q, outVsync_q, outHblnk_q, outVblnk_q;
    logic [RGB_W-1:0]   outRgb_q;
    logic               switching_q;

    assign selValid = (32'(sel) < N_SRC_U);

    // Start of frame is judged on the source currently on screen, not the one being switched to.
    always_comb begin
        sof = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (activeSel_q == SEL_W'(i)) begin
                sof = (src_hcount[i*CNT_W +: CNT_W] == '0) &&
                      (src_vcount[i*CNT_W +: CNT_W] == '0);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        activeSel_d = activeSel_q;
        blankCnt_d  = blankCnt_q;
        case (state_q)
            IDLE: begin
                if (selValid && (sel != activeSel_q)) begin
                    target_d = sel;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (selValid) begin
                    target_d = sel;
                end
                if (selValid && (sel == activeSel_q)) begin
                    state_d = IDLE;
                end else if (sof) begin
                    activeSel_d = target_d;
                    if (BLANK_FRAMES > 0) begin
                        state_d    = BLANKING;
                        blankCnt_d = BLANK_W'(BLANK_FRAMES);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BLANKING: begin
                if (selValid) begin
                    target_d = sel;
                end
                if (sof) begin
                    blankCnt_d = blankCnt_q - 1'b1;
                    if (blankCnt_q == BLANK_W'(1)) begin
                        state_d = (target_d != activeSel_q) ? PENDING : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            activeSel_q <= '0;
            blankCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            activeSel_q <= activeSel_d;
            blankCnt_q  <= blankCnt_d;
        end
    end

    // Indexed by the next committed source so the switch edge already carries the new frame's first pixel.
    vga_src_sel #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W),
        .RGB_W (RGB_W),
        .CNT_W (CNT_W)
    ) u_src_sel (
        .idx_i    (activeSel_d),
        .hcount_i (src_hcount),
        .vcount_i (src_vcount),
        .hsync_i  (src_hsync),
        .vsync_i  (src_vsync),
        .hblnk_i  (src_hblnk),
        .vblnk_i  (src_vblnk),
        .rgb_i    (src_rgb),
        .hcount_o (pickHcount),
        .vcount_o (pickVcount),
        .hsync_o  (pickHsync),
        .vsync_o  (pickVsync),
        .hblnk_o  (pickHblnk),
        .vblnk_o  (pickVblnk),
        .rgb_o    (pickRgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            outHcount_q <= '0;
            outVcount_q <= '0;
            outHsync_q  <= 1'b0;
            outVsync_q  <= 1'b0;
            outHblnk_q  <= 1'b0;
            outVblnk_q  <= 1'b0;
            outRgb_q    <= '0;
            switching_q <= 1'b0;
        end else begin
            outHcount_q <= pickHcount;
            outVcount_q <= pickVcount;
            outHsync_q  <= pickHsync;
            outVsync_q  <= pickVsync;
            outHblnk_q  <= pickHblnk;
            outVblnk_q  <= pickVblnk;
            outRgb_q    <= (state_d == BLANKING) ? '0 : pickRgb;
            switching_q <= (state_d != IDLE);
        end
    end

    assign out_hcount = outHcount_q;
    assign out_vcount = outVcount_q;
    assign out_hsync  = outHsync_q;
    assign out_vsync  = outVsync_q;
    assign out_hblnk  = outHblnk_q;
    assign out_vblnk  = outVblnk_q;
    assign out_rgb    = outRgb_q;
    assign active_sel = activeSel_q;
    assign switching  = switching_q;

endmodule
